segscan_ctrl: RTL and testbench



---
 rtl/segscan_pkg.sv | 13 +
 rtl/segdriver.sv | 28 ++
 rtl/segscan_ctrl.sv | 115 +++++++++++
 tb/tb_segscan_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/segscan_pkg.sv
// Shared widths, segment constants and index type for the segment scan controller.
package segscan_pkg;

  localparam int SEG_W = 8;
  localparam int BCD_W = 4;
  localparam int IDX_W = 3;

  localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;
  localparam logic [SEG_W-1:0] SEG_ERR   = 8'h01;

  typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/segdriver.sv
// Combinational BCD-to-7-segment decoder: seg = {a..g, dp}, active-high.
module segdriver
  import segscan_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  input  logic             dot,
  output logic [SEG_W-1:0] seg
);

  // Non-BCD codes light only the decimal point so bad data is visible.
  always_comb begin
    seg = SEG_ERR;
    case (bcd)
      4'd0: seg = {7'b1111110, dot};
      4'd1: seg = {7'b0110000, dot};
      4'd2: seg = {7'b1101101, dot};
      4'd3: seg = {7'b1111001, dot};
      4'd4: seg = {7'b0110011, dot};
      4'd5: seg = {7'b1011011, dot};
      4'd6: seg = {7'b1011111, dot};
      4'd7: seg = {7'b1110000, dot};
      4'd8: seg = {7'b1111111, dot};
      4'd9: seg = {7'b1111011, dot};
      default: seg = SEG_ERR;
    endcase
  end

endmodule

// File: rtl/segscan_ctrl.sv
// Time-multiplexed NDIG-digit 7-segment scan controller with a frame-synchronous double buffer.
// Optional leading-zero blanking is enabled by defining SEGSCAN_LZB_EN.
module segscan_ctrl
  import segscan_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [BCD_W*NDIG-1:0] bcd_in,
  input  logic [NDIG-1:0]       dots_in,
  output logic [SEG_W-1:0]      seg_out,
  output logic [NDIG-1:0]       dig_en,
  output logic                  frame_done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]         presc;
  idx_t                  idx;
  logic [BCD_W*NDIG-1:0] shadow_bcd, active_bcd, next_bcd;
  logic [NDIG-1:0]       shadow_dots, active_dots, next_dots;
  logic                  pending;
  logic                  boundary;
  logic [BCD_W-1:0]      cur_bcd;
  logic                  cur_dot;
  logic [SEG_W-1:0]      dec_seg, seg_next;

  assign boundary  = (presc == PW'(PRESCALE - 1)) && (idx == idx_t'(NDIG - 1));
  assign next_bcd  = load ? bcd_in  : shadow_bcd;
  assign next_dots = load ? dots_in : shadow_dots;
  assign cur_bcd   = active_bcd[BCD_W*int'(idx) +: BCD_W];
  assign cur_dot   = active_dots[idx];

  segdriver u_driver (
    .bcd (cur_bcd),
    .dot (cur_dot),
    .seg (dec_seg)
  );

`ifdef SEGSCAN_LZB_EN
  logic [NDIG-1:0] active_blank;

  // Digits above the highest non-zero digit are dark; digit 0 always shows.
  function automatic logic [NDIG-1:0] lzb_mask(input logic [BCD_W*NDIG-1:0] bcd);
    logic seen;
    seen     = 1'b0;
    lzb_mask = '0;
    for (int i = NDIG - 1; i >= 1; i--) begin
      if (bcd[BCD_W*i +: BCD_W] != '0) seen = 1'b1;
      lzb_mask[i] = ~seen;
    end
  endfunction

  assign seg_next = active_blank[idx] ? {7'b0, cur_dot} : dec_seg;
`else
  assign seg_next = dec_seg;
`endif

  // Active buffer only changes at the frame boundary so a frame never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc       <= '0;
      idx         <= '0;
      shadow_bcd  <= '0;
      shadow_dots <= '0;
      active_bcd  <= '0;
      active_dots <= '0;
      pending     <= 1'b0;
      seg_out     <= SEG_BLANK;
      dig_en      <= '0;
      frame_done  <= 1'b0;
`ifdef SEGSCAN_LZB_EN
      active_blank <= lzb_mask('0);
`endif
    end else begin
      frame_done <= boundary;

      if (presc == PW'(PRESCALE - 1)) begin
        presc <= '0;
        idx   <= (idx == idx_t'(NDIG - 1)) ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end

      if (load) begin
        shadow_bcd  <= bcd_in;
        shadow_dots <= dots_in;
      end

      if (boundary) pending <= 1'b0;
      else if (load) pending <= 1'b1;

      if (boundary && (pending || load)) begin
        active_bcd  <= next_bcd;
        active_dots <= next_dots;
`ifdef SEGSCAN_LZB_EN
        active_blank <= lzb_mask(next_bcd);
`endif
      end

      if (int'(presc) < BLANK) begin
        seg_out <= SEG_BLANK;
        dig_en  <= '0;
      end else begin
        seg_out <= seg_next;
        dig_en  <= NDIG'(1) << idx;
      end
    end
  end

endmodule

// File: tb/tb_segscan_ctrl.sv
// Self-checking bench for segscan_ctrl (NDIG=4, PRESCALE=8, BLANK=2): vector table, corner sequences, random run.
// Expectations follow SEGSCAN_LZB_EN when it is defined.
module tb_segscan_ctrl;

  localparam int NDIG     = 4;
  localparam int PRESCALE = 8;
  localparam int BLANK    = 2;
  localparam int FRAME    = NDIG * PRESCALE;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                load = 1'b0;
  logic [4*NDIG-1:0]   bcd_in = '0;
  logic [NDIG-1:0]     dots_in = '0;
  logic [7:0]          seg_out;
  logic [NDIG-1:0]     dig_en;
  logic                frame_done;

  segscan_ctrl #(.NDIG(NDIG), .PRESCALE(PRESCALE), .BLANK(BLANK)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .bcd_in     (bcd_in),
    .dots_in    (dots_in),
    .seg_out    (seg_out),
    .dig_en     (dig_en),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: elapsed cycles since reset plus the buffer contents.
  int              m_k = 0;
  logic [15:0]     m_shadow = '0, m_active = '0;
  logic [3:0]      m_sdots = '0, m_adots = '0;
  bit              m_pending = 0;
  logic [6:0]      segtab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                   7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  function automatic logic [7:0] ref_seg(input logic [15:0] val, input logic [3:0] dots, input int d);
    int digit, hi;
    digit = int'((val >> (4 * d)) & 16'hF);
    hi = 0;
    for (int i = 0; i < NDIG; i++)
      if (((val >> (4 * i)) & 16'hF) != 0) hi = i;
`ifdef SEGSCAN_LZB_EN
    if (d > hi && d != 0) return {7'b0, dots[d]};
`endif
    if (digit > 9) return 8'h01;
    return {segtab[digit], dots[d]};
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the DUT, compare all outputs against the model.
  task automatic applyStimulus(input bit r, input bit ld, input logic [15:0] b, input logic [3:0] d);
    logic [7:0] e_seg;
    logic [3:0] e_dig;
    logic       e_fd;
    int         slot, presc;
    bit         bnd;
    rst = r; load = ld; bcd_in = b; dots_in = d;
    presc = m_k % PRESCALE;
    slot  = (m_k / PRESCALE) % NDIG;
    bnd   = (m_k % FRAME) == FRAME - 1;
    e_seg = 8'h00; e_dig = 4'h0; e_fd = 1'b0;
    if (!r) begin
      e_fd = bnd;
      if (presc >= BLANK) begin
        e_dig = 4'(1 << slot);
        e_seg = ref_seg(m_active, m_adots, slot);
      end
    end
    @(posedge clk);
    #1;
    checkOutput("seg_out", seg_out, e_seg);
    checkOutput("dig_en", {4'h0, dig_en}, {4'h0, e_dig});
    checkOutput("frame_done", {7'h0, frame_done}, {7'h0, e_fd});
    if (r) begin
      m_k = 0; m_shadow = '0; m_sdots = '0; m_active = '0; m_adots = '0; m_pending = 0;
    end else begin
      if (bnd && (m_pending || ld)) begin
        m_active = ld ? b : m_shadow;
        m_adots  = ld ? d : m_sdots;
        m_pending = 0;
      end else if (ld) begin
        m_pending = 1;
      end
      if (ld) begin
        m_shadow = b; m_sdots = d;
      end
      m_k++;
    end
  endtask

  task automatic runUntil(input int phase);
    int guard = 0;
    do begin
      applyStimulus(0, 0, 16'h0, 4'h0);
      guard++;
    end while ((m_k % FRAME) != phase && guard < 2 * FRAME);
    if ((m_k % FRAME) != phase) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL runUntil: phase %0d, expected %0d", m_k % FRAME, phase);
    end
  endtask

  typedef struct {
    logic [15:0]     bcd;
    logic [3:0]      dots;
    logic [3:0][7:0] exp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{16'h1234, 4'b0000, {8'h60, 8'hDA, 8'hF2, 8'h66}};
    vecs[1] = '{16'h9999, 4'b1000, {8'hF7, 8'hF6, 8'hF6, 8'hF6}};
    vecs[2] = '{16'h80C5, 4'b0010, {8'hFE, 8'hFC, 8'h01, 8'hB6}};
`ifdef SEGSCAN_LZB_EN
    vecs[3] = '{16'h0070, 4'b1000, {8'h01, 8'h00, 8'hE0, 8'hFC}};
    vecs[4] = '{16'h0000, 4'b0101, {8'h00, 8'h01, 8'h00, 8'hFD}};
`else
    vecs[3] = '{16'h0070, 4'b1000, {8'hFD, 8'hFC, 8'hE0, 8'hFC}};
    vecs[4] = '{16'h0000, 4'b0101, {8'hFC, 8'hFD, 8'hFC, 8'hFD}};
`endif

    applyStimulus(1, 0, 16'h0, 4'h0);
    applyStimulus(1, 0, 16'h0, 4'h0);
    checkOutput("reset seg_out", seg_out, 8'h00);
    checkOutput("reset dig_en", {4'h0, dig_en}, 8'h00);

    // Table: load, wait for the next frame, sample each slot mid-lit.
    for (int v = 0; v < 5; v++) begin
      applyStimulus(0, 1, vecs[v].bcd, vecs[v].dots);
      runUntil(0);
      for (int s = 0; s < NDIG; s++) begin
        runUntil(s * PRESCALE + 5);
        checkOutput($sformatf("vec%0d slot%0d seg", v, s), seg_out, vecs[v].exp[s]);
        checkOutput($sformatf("vec%0d slot%0d dig", v, s), {4'h0, dig_en}, 8'(1 << s));
      end
    end

    // Mid-frame load must not tear the frame in progress.
    applyStimulus(0, 1, 16'h1234, 4'h0);
    runUntil(0);
    runUntil(10);
    applyStimulus(0, 1, 16'h5678, 4'h0);
    runUntil(29);
    checkOutput("no-tear slot3", seg_out, 8'h60);
    runUntil(0);
    checkOutput("frame_done pulse", {7'h0, frame_done}, 8'h01);
    runUntil(1);
    checkOutput("frame_done one cycle", {7'h0, frame_done}, 8'h00);
    runUntil(5);
    checkOutput("new frame slot0", seg_out, 8'hFE);

    // Load in the boundary cycle goes straight to the active buffer.
    runUntil(31);
    applyStimulus(0, 1, 16'h9999, 4'b1000);
    runUntil(5);
    checkOutput("boundary load slot0", seg_out, 8'hF6);
    runUntil(29);
    checkOutput("boundary load slot3", seg_out, 8'hF7);

    // Reset during the lit phase of slot 2.
    runUntil(20);
    applyStimulus(1, 0, 16'h0, 4'h0);
    checkOutput("mid reset seg", seg_out, 8'h00);
    checkOutput("mid reset dig", {4'h0, dig_en}, 8'h00);
    checkOutput("mid reset fd", {7'h0, frame_done}, 8'h00);
    runUntil(5);
    checkOutput("restart seg", seg_out, 8'hFC);
    checkOutput("restart dig", {4'h0, dig_en}, 8'h01);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit r, ld;
      logic [15:0] b;
      r  = ($urandom_range(0, 499) == 0);
      ld = ($urandom_range(0, 7) == 0);
      b  = 16'($urandom);
      if ($urandom_range(0, 3) != 0)
        for (int j = 0; j < 4; j++)
          if (((b >> (4 * j)) & 16'hF) > 9) b = b & ~(16'h8 << (4 * j));
      applyStimulus(r, ld, b, 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
